// File: rtl/wb_data_ram_if.sv
// Wishbone classic bus bundle between the load/store unit (master) and the data RAM (slave).
interface wishbone #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] ADR;
    logic [XLEN-1:0] DAT_W;
    logic [XLEN-1:0] DAT_R;
    logic [3:0]      SEL;
    logic            WE;
    logic            STB;
    logic            ACK;

    modport SLAVE  (input ADR, DAT_W, SEL, WE, STB, output DAT_R, ACK);
    modport MASTER (output ADR, DAT_W, SEL, WE, STB, input DAT_R, ACK);
endinterface

// File: rtl/wb_data_ram.sv
// Wishbone classic data RAM with byte-lane decode and configurable wait states.
// Optional misaligned-access trap is enabled with the DRAM_MISALIGN_TRAP_EN macro.
module wb_data_ram #(
    parameter int             XLEN        = 32,
    parameter int             DEPTH       = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int             WAIT_STATES = 0
) (
    input  logic   clk,
    input  logic   rst,
    wishbone.SLAVE mm_bus
`ifdef DRAM_MISALIGN_TRAP_EN
    ,
    output logic   misaligned
`endif
);
    localparam int              AW   = $clog2(DEPTH);
    localparam logic [XLEN-1:0] SPAN = XLEN'(DEPTH * 4);
    localparam logic [3:0]      WS   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_idx;
    logic [1:0]      r_off;
    logic            r_we;
    logic            r_in_range;
    logic            r_bad;
    logic            r_ack;
    logic [XLEN-1:0] r_dat_r;
    logic [XLEN-1:0] r_mem [DEPTH];

    logic [XLEN-1:0] w_rel;
    logic            w_in_range;
    logic [AW-1:0]   w_idx;
    logic [1:0]      w_off;
    logic [3:0]      w_lanes;
    logic [XLEN-1:0] w_wdata;
    logic            w_misal;
    logic            w_wr_en;
    logic [XLEN-1:0] w_rd_word;

    // Request decode: lane shift and word index relative to the RAM window.
    always_comb begin
        w_rel      = mm_bus.ADR - BASE_ADDR;
        w_in_range = (w_rel < SPAN);
        w_idx      = w_rel[AW+1:2];
        w_off      = mm_bus.ADR[1:0];
        w_lanes    = mm_bus.SEL << w_off;
        w_wdata    = mm_bus.DAT_W << {w_off, 3'b000};
`ifdef DRAM_MISALIGN_TRAP_EN
        w_misal    = ((mm_bus.SEL == 4'b0011) && w_off[0]) ||
                     ((mm_bus.SEL == 4'b1111) && (w_off != 2'b00));
`else
        w_misal    = 1'b0;
`endif
        w_wr_en    = !rst && (r_state == S_IDLE) && mm_bus.STB && mm_bus.WE &&
                     w_in_range && (w_lanes != 4'b0000) && !w_misal;
    end

    // Read path: captured word shifted down, zero-filled from the top.
    always_comb begin
        if (r_in_range && !r_bad) begin
            w_rd_word = r_mem[r_idx] >> {r_off, 3'b000};
        end else begin
            w_rd_word = '0;
        end
    end

    // Stores commit on the capture edge since the LSU may drop STB right after.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lanes[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered ACK and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_off      <= 2'd0;
            r_we       <= 1'b0;
            r_in_range <= 1'b0;
            r_bad      <= 1'b0;
            r_ack      <= 1'b0;
            r_dat_r    <= '0;
`ifdef DRAM_MISALIGN_TRAP_EN
            misaligned <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mm_bus.STB) begin
                        r_idx      <= w_idx;
                        r_off      <= w_off;
                        r_we       <= mm_bus.WE;
                        r_in_range <= w_in_range;
                        r_bad      <= w_misal;
                        r_cnt      <= WS;
                        r_state    <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ack   <= 1'b1;
                    r_state <= S_IDLE;
                    if (!r_we) begin
                        r_dat_r <= w_rd_word;
                    end
`ifdef DRAM_MISALIGN_TRAP_EN
                    if (r_bad) begin
                        misaligned <= 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mm_bus.ACK   = r_ack;
    assign mm_bus.DAT_R = r_dat_r;
endmodule

// File: tb/tb_wb_data_ram.sv
// Scoreboard bench: two RAM instances (0 and 3 wait states) driven with identical
// accesses and checked against a byte-addressed reference model.
module tb_wb_data_ram;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SPAN = 32'd4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = 32'd0;
    logic [31:0] dat_w = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic        we = 1'b0;
    logic        stb0 = 1'b0;
    logic        stb3 = 1'b0;

    always #5 clk = ~clk;

    wishbone #(.XLEN(32)) bus0 ();
    wishbone #(.XLEN(32)) bus3 ();

    assign bus0.ADR = adr;   assign bus3.ADR = adr;
    assign bus0.DAT_W = dat_w; assign bus3.DAT_W = dat_w;
    assign bus0.SEL = sel;   assign bus3.SEL = sel;
    assign bus0.WE = we;     assign bus3.WE = we;
    assign bus0.STB = stb0;  assign bus3.STB = stb3;

    wb_data_ram #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .mm_bus(bus0));
    wb_data_ram #(.XLEN(32), .DEPTH(1024), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .mm_bus(bus3));

    typedef struct {
        logic [31:0] data;
        int          ack_cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q3[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  mb [int];
    logic [31:0] last_r = 32'd0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a - BASE) < SPAN;
    endfunction

    // Reference model: byte k of the request lands at byte (off+k) of the word if it fits.
    task automatic model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int base;
        int off;
        if (in_rng(a)) begin
            base = int'((a - BASE) & 32'hFFFF_FFFC);
            off  = int'(a[1:0]);
            for (int k = 0; k < 4; k++) begin
                if (s[k] && (k + off < 4)) mb[base + k + off] = d[8*k +: 8];
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        int base;
        int off;
        r = 32'd0;
        if (in_rng(a)) begin
            base = int'((a - BASE) & 32'hFFFF_FFFC);
            off  = int'(a[1:0]);
            for (int k = 0; k < 4; k++) begin
                if (k + off < 4) r[8*k +: 8] = mb.exists(base + k + off) ? mb[base + k + off] : 8'h00;
            end
        end
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every ACK pops one expectation per instance and checks data and latency.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus0.ACK === 1'b1) begin
            if (q0.size() == 0) cmp("ack0_unexpected", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                cmp("ws0_latency", 32'(cyc), 32'(e.ack_cyc));
                cmp("ws0_dat_r", bus0.DAT_R, e.data);
            end
        end
        if (bus3.ACK === 1'b1) begin
            if (q3.size() == 0) cmp("ack3_unexpected", 32'd1, 32'd0);
            else begin
                e = q3.pop_front();
                cmp("ws3_latency", 32'(cyc), 32'(e.ack_cyc));
                cmp("ws3_dat_r", bus3.DAT_R, e.data);
            end
        end
    end

    // One access on both instances; hold keeps STB up until that instance ACKs.
    task automatic do_op(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic hold,
                         input logic use_k, input logic [31:0] k);
        exp_t e;
        bit   seen0;
        bit   seen3;
        if (w) model_write(a, s, d);
        else   last_r = model_read(a);
        e.data = use_k ? k : last_r;
        e.ack_cyc = cyc + 2;
        q0.push_back(e);
        e.ack_cyc = cyc + 5;
        q3.push_back(e);
        adr = a; sel = s; dat_w = d; we = w;
        stb0 = 1'b1; stb3 = 1'b1;
        seen0 = 1'b0; seen3 = 1'b0;
        for (int n = 0; n < 20 && !(seen0 && seen3); n++) begin
            @(posedge clk); #1;
            if (!hold) begin stb0 = 1'b0; stb3 = 1'b0; end
            if (bus0.ACK === 1'b1) begin seen0 = 1'b1; stb0 = 1'b0; end
            if (bus3.ACK === 1'b1) begin seen3 = 1'b1; stb3 = 1'b0; end
        end
        if (!(seen0 && seen3)) cmp("ack_timeout", {30'd0, seen3, seen0}, 32'd3);
        stb0 = 1'b0; stb3 = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        do_op(1'b1, a, s, d, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic rd_k(input logic [31:0] a, input logic [3:0] s, input logic hold, input logic [31:0] k);
        do_op(1'b0, a, s, 32'd0, hold, 1'b1, k);
    endtask

    task automatic check_idle(input string tag);
        cmp({tag, "_ack0"}, {31'd0, bus0.ACK}, 32'd0);
        cmp({tag, "_ack3"}, {31'd0, bus3.ACK}, 32'd0);
        cmp({tag, "_dat0"}, bus0.DAT_R, 32'd0);
        cmp({tag, "_dat3"}, bus3.DAT_R, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        int          w;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");

        // Word store then load, STB held and dropped.
        wr(32'h10, 4'b1111, 32'hDEAD_BEEF);
        rd_k(32'h10, 4'b1111, 1'b1, 32'hDEAD_BEEF);
        // Byte lanes.
        wr(32'h13, 4'b0001, 32'h0000_00AA);
        rd_k(32'h10, 4'b1111, 1'b0, 32'hAAAD_BEEF);
        rd_k(32'h13, 4'b0001, 1'b1, 32'h0000_00AA);
        rd_k(32'h12, 4'b0011, 1'b0, 32'h0000_AAAD);
        // Out of range: dropped write must not alias onto word 0.
        wr(32'h0, 4'b1111, 32'h0BAD_F00D);
        wr(BASE + 32'h1000, 4'b1111, 32'h1234_5678);
        rd_k(BASE + 32'h1000, 4'b1111, 1'b0, 32'h0000_0000);
        rd_k(32'h0, 4'b1111, 1'b1, 32'h0BAD_F00D);
        // Misaligned half-word store truncates at byte 3.
        wr(32'h13, 4'b0011, 32'h0000_1234);
        rd_k(32'h10, 4'b1111, 1'b0, 32'h34AD_BEEF);
        // Top word boundary and SEL=0 store.
        wr(32'hFFC, 4'b1111, 32'hCAFE_0123);
        rd_k(32'hFFE, 4'b0011, 1'b0, 32'h0000_CAFE);
        wr(32'h10, 4'b0000, 32'hFFFF_FFFF);
        rd_k(32'h10, 4'b1111, 1'b0, 32'h34AD_BEEF);

        // Reset during WAIT of the slow instance; the committed store survives.
        model_write(32'h20, 4'b1111, 32'h5555_AAAA);
        begin
            exp_t e;
            e.data = last_r;
            e.ack_cyc = cyc + 2;
            q0.push_back(e);
        end
        adr = 32'h20; sel = 4'b1111; dat_w = 32'h5555_AAAA; we = 1'b1;
        stb0 = 1'b1; stb3 = 1'b1;
        @(posedge clk); #1;
        stb0 = 1'b0; stb3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        last_r = 32'd0;
        check_idle("midwait_reset");
        rd_k(32'h20, 4'b1111, 1'b1, 32'h5555_AAAA);

        // Preload the random window so every read hits known bytes.
        for (int i = 0; i < 16; i++) wr(32'(i * 4), 4'b1111, $urandom);
        wr(32'hFFC, 4'b1111, $urandom);

        for (int i = 0; i < 200; i++) begin
            w = $urandom_range(0, 16);
            a = (w == 16) ? 32'hFFC : 32'(w * 4);
            a[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 8191));
            case ($urandom_range(0, 3))
                0: s = 4'b0001;
                1: s = 4'b0011;
                2: s = 4'b1111;
                default: s = 4'($urandom_range(0, 15));
            endcase
            do_op(1'($urandom_range(0, 1)), a, s, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'd0);
        end

        repeat (8) @(posedge clk);
        #1;
        cmp("q0_drained", 32'(q0.size()), 32'd0);
        cmp("q3_drained", 32'(q3.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_data_ram.md
Name: wb_data_ram

Overview:
- Wishbone classic slave data memory sitting directly downstream of the core's load/store unit on its `mm_bus` master port.
- Decodes byte-lane position from the low address bits. The LSU presents store data and SEL right-justified in the low lanes and expects load data right-justified.
- Returns a registered ACK after a configurable number of wait states.
- The LSU extends loaded data; this block does not.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- DEPTH, 1024, memory size in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.
- WAIT_STATES, 0, extra cycles between request capture and ACK (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mm_bus  wishbone.SLAVE  -  uses ADR[XLEN-1:0], DAT_W[XLEN-1:0], SEL[3:0], WE, STB in; DAT_R[XLEN-1:0], ACK out.
- misaligned  output  1  present only with DRAM_MISALIGN_TRAP_EN; see Optional Feature.

Behaviour:
- Reset (synchronous, active-high; overrides everything including mid-transaction):
  - state=IDLE; ACK=0; DAT_R=0; wait counter=0.
  - Memory contents are not cleared.
  - Any in-flight transaction is abandoned; a write already committed stays committed.
- Decode:
  - off=ADR[1:0].
  - in_range = (ADR-BASE_ADDR) < DEPTH*4.
  - idx=(ADR-BASE_ADDR)[log2(DEPTH)+1:2].
  - lanes = (SEL<<off) truncated to 4 bits.
  - wdata = DAT_W<<(8*off).
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - On STB=1, capture ADR/SEL/WE.
    - If WE, in_range and lanes!=0, write the selected bytes of wdata into mem[idx] this same cycle. Writes commit at capture because the LSU may hold STB for only one cycle on stores.
    - Load counter with WAIT_STATES.
    - Go to RESP if WAIT_STATES==0, else WAIT.
  - WAIT: decrement counter; go to RESP when counter reaches 1.
  - RESP:
    - ACK=1 for exactly one cycle.
    - For reads: DAT_R = in_range ? mem[idx_captured]>>(8*off_captured) : 0, zero-filled from the top.
    - For writes: DAT_R holds its previous value.
    - Next state is IDLE unconditionally; STB is ignored in this cycle.
- Latency: ACK rises exactly WAIT_STATES+1 cycles after the capture edge. ACK is never asserted in the capture cycle; the LSU requires ACK to arrive no earlier than one cycle after the request.
- STB deasserted during WAIT: the transaction still completes and ACKs.
- Back-to-back requests:
  - A new request is accepted on the cycle after RESP. Max throughput is 1 access per WAIT_STATES+2 cycles.
  - A read following a write to the same word returns the new data.
- DAT_R is registered and holds its value between ACKs.
- Out-of-range accesses: write dropped, read returns 0, ACK still produced with normal latency.
- Misaligned access (half with off[0]=1, or word with off!=0), without the macro:
  - Lanes shifted past byte 3 are dropped; no wrap into the next word.
  - Reads return the shifted, truncated word.
- SEL=0 on a write: no bytes written, ACK still produced.

Optional Feature:
- Macro: DRAM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port `misaligned`; reset value 0.
  - On capture of a misaligned request, the write is suppressed and a read returns DAT_R=0.
  - ACK is still produced with normal latency.
  - `misaligned` goes high on the RESP cycle of that access and stays set until rst.
- Undefined: port absent; truncating behaviour as in Behaviour.

Test Plan:
- Reset: hold rst 2 cycles mid-WAIT with WAIT_STATES=3 -> ACK=0, DAT_R=0 after release; next request ACKs after 4 cycles.
- Word write then read, WAIT_STATES=0:
  - Store: STB+WE, ADR=0x10, SEL=4'b1111, DAT_W=0xDEADBEEF for 1 cycle -> ACK exactly 1 cycle later.
  - Load: from 0x10 -> ACK 1 cycle after STB, DAT_R=0xDEADBEEF, ACK high exactly 1 cycle.
- Byte lanes:
  - Store: SB DAT_W=0x000000AA, SEL=4'b0001, ADR=0x13.
  - LW 0x10 -> 0xAAADBEEF.
  - LB 0x13 -> DAT_R=0x000000AA.
  - LH 0x12 -> DAT_R=0x0000AAAD.
- Wait states: WAIT_STATES=3, read with STB held -> ACK on 4th edge after capture. Repeat with STB dropped after 1 cycle -> ACK still on 4th edge.
- Out of range: with DEPTH=1024, write 0x12345678 to BASE_ADDR+0x1000 -> ACK, memory unchanged; read same address -> DAT_R=0.
- Misaligned:
  - Without macro: SH 0x1234 at 0x13 -> only byte 3 of word 0x10 becomes 0x34.
  - With DRAM_MISALIGN_TRAP_EN: same store -> word unchanged, `misaligned`=1 from the RESP cycle, and it stays 1 through later aligned accesses until rst.
